// File: rtl/solver_result_reader.sv
// solver_result_reader: drains the per-solver result RAMs of the multi-solver
// array once it reports done. Words leave in solver/address order on a
// valid/ready stream tagged with solver id, address and a last flag.
//
// Stream handshake: out_valid means the out_* fields hold a word. A word
// transfers on a rising edge where out_valid & out_ready are both high.
// While out_valid is high and out_ready is low, every out_* field holds its
// value. out_valid never depends on out_ready.
//
// Read pipeline: a read is issued by loading the pointer into the read-port
// register. The array RAM latches that address at the next edge. The word then
// sits on rd_data_in until the port address changes, so an uncaptured word
// survives as long as no further read is issued. A read is only issued when
// the word then sitting on rd_data_in is guaranteed a FIFO slot at the
// following edge. Together with the 2-entry FIFO, this gives one word per
// cycle when out_ready stays high, and it never drops a word.
module solver_result_reader #(
  parameter int NUM_SOLVERS      = 1,
  parameter int WORDS_PER_SOLVER = 1024,
  parameter int ID_W             = 6,
  parameter int ADDR_W           = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              solvers_done,
  output logic [ID_W-1:0]   rd_solver_id,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [ID_W-1:0]   out_solver_id,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              frame_done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_DONE = 3'd1,
    S_READ      = 3'd2,
    S_FLUSH     = 3'd3,
    S_FINISH    = 3'd4
  } state_t;

  localparam int ENTRY_W = 1 + ID_W + ADDR_W + 8;
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_SOLVERS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS_PER_SOLVER - 1);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_id_q, ptr_id_d;
  logic [ADDR_W-1:0]   ptr_addr_q, ptr_addr_d;
  logic                issue;

  // read-port register and the two in-flight stages
  logic [ID_W-1:0]     rd_id_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                rd_last_q;
  logic                s1_q;          // address on the port, not yet latched by the RAM
  logic                s2_q;          // word on rd_data_in, not yet captured
  logic [ID_W-1:0]     m2_id_q;
  logic [ADDR_W-1:0]   m2_addr_q;
  logic                m2_last_q;

  // 2-entry output FIFO
  logic [ENTRY_W-1:0]  fifo_q [2];
  logic                wr_ptr_q, rd_ptr_q;
  logic [1:0]          cnt_q;

  logic                ptr_final;
  logic                accept;
  logic                capture;
  logic [1:0]          cnt_after;
  logic                s2_after;
  logic                can_issue;

  assign ptr_final = (ptr_id_q == LAST_ID) && (ptr_addr_q == LAST_ADDR);
  assign accept    = out_valid & out_ready;
  assign capture   = s2_q && ((cnt_q != 2'd2) || accept);
  assign cnt_after = cnt_q + {1'b0, capture} - {1'b0, accept};
  assign s2_after  = s1_q | (s2_q & ~capture);
  assign can_issue = ~s2_after | (cnt_after < 2'd2);

  assign out_valid = (cnt_q != 2'd0);
  assign {out_last, out_solver_id, out_addr, out_data} = fifo_q[rd_ptr_q];
  assign rd_solver_id = rd_id_q;
  assign rd_addr      = rd_addr_q;
  assign busy         = (state_q != S_IDLE);
  assign frame_done   = (state_q == S_FINISH);
  assign dbg_state    = state_q;

  // next state, read pointer advance and read-issue decision
  always_comb begin
    state_d    = state_q;
    ptr_id_d   = ptr_id_q;
    ptr_addr_d = ptr_addr_q;
    issue      = 1'b0;
    case (state_q)
      S_IDLE: begin
        ptr_id_d   = '0;
        ptr_addr_d = '0;
        if (start) state_d = solvers_done ? S_READ : S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (solvers_done) state_d = S_READ;
      end
      S_READ: begin
        if (can_issue) begin
          issue = 1'b1;
          if (ptr_final) begin
            state_d = S_FLUSH;
          end else if (ptr_addr_q == LAST_ADDR) begin
            ptr_addr_d = '0;
            ptr_id_d   = ptr_id_q + ID_W'(1);
          end else begin
            ptr_addr_d = ptr_addr_q + ADDR_W'(1);
          end
        end
      end
      S_FLUSH: begin
        if (accept && out_last) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM state and read pointer registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ptr_id_q   <= '0;
      ptr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_id_q   <= ptr_id_d;
      ptr_addr_q <= ptr_addr_d;
    end
  end

  // read port (held between issues) and in-flight tracking with word metadata
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_id_q   <= '0;
      rd_addr_q <= '0;
      rd_last_q <= 1'b0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      m2_id_q   <= '0;
      m2_addr_q <= '0;
      m2_last_q <= 1'b0;
    end else begin
      s1_q <= issue;
      s2_q <= s2_after;
      if (issue) begin
        rd_id_q   <= ptr_id_q;
        rd_addr_q <= ptr_addr_q;
        rd_last_q <= ptr_final;
      end
      if (s1_q) begin
        m2_id_q   <= rd_id_q;
        m2_addr_q <= rd_addr_q;
        m2_last_q <= rd_last_q;
      end
    end
  end

  // output FIFO: capture from the RAM, pop on downstream accept
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (capture) begin
        fifo_q[wr_ptr_q] <= {m2_last_q, m2_id_q, m2_addr_q, rd_data_in};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (accept) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_after;
    end
  end

endmodule

// File: tb/tb_solver_result_reader.sv
// Bench for solver_result_reader with 2 solvers x 4 words. A synchronous RAM
// model sits on the read port. Expected words come from the RAM contents in
// solver/address order and are compared as the stream delivers them.
module tb_solver_result_reader;

  localparam int NS = 2;
  localparam int WPS = 4;
  localparam int ID_W = 6;
  localparam int ADDR_W = 10;
  localparam int EW = 1 + ID_W + ADDR_W + 8;

  logic              clock;
  logic              reset;
  logic              start;
  logic              solvers_done;
  logic [ID_W-1:0]   rd_solver_id;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data_in;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic [ID_W-1:0]   out_solver_id;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              busy;
  logic              frame_done;
  logic [2:0]        dbg_state;

  logic [7:0]        mem [NS][WPS];
  logic [EW-1:0]     exp_q[$];
  int                n_checks = 0;
  int                n_pass = 0;
  int                acc_cnt = 0;
  int                fd_count = 0;
  int                fd_stage = 0;
  logic              held_v = 1'b0;
  logic [EW-1:0]     held_w = '0;

  solver_result_reader #(
    .NUM_SOLVERS(NS), .WORDS_PER_SOLVER(WPS), .ID_W(ID_W), .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .solvers_done(solvers_done),
    .rd_solver_id(rd_solver_id), .rd_addr(rd_addr), .rd_data_in(rd_data_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_solver_id(out_solver_id), .out_addr(out_addr), .out_last(out_last),
    .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // synchronous result RAM of the solver array
  always @(posedge clock) begin
    if (rd_solver_id < ID_W'(NS) && rd_addr < ADDR_W'(WPS))
      rd_data_in <= mem[rd_solver_id[0]][rd_addr[1:0]];
    else
      rd_data_in <= 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [EW-1:0] cur_word();
    return {out_last, out_solver_id, out_addr, out_data};
  endfunction

  // scoreboard: pops one expected word per accepted transfer, checks stall
  // stability and the frame_done pulse that follows the last word
  always @(negedge clock) begin
    logic [EW-1:0] e;
    if (!reset) begin
      held_v   = 1'b0;
      fd_stage = 0;
    end else begin
      if (frame_done) fd_count++;
      if (fd_stage == 1) begin
        check("fd_pulse", 32'(frame_done), 1);
        fd_stage = 2;
      end else if (fd_stage == 2) begin
        check("fd_one_cycle", 32'(frame_done), 0);
        fd_stage = 0;
      end
      if (held_v) check("stall_stable", 32'({out_valid, cur_word()}), 32'({1'b1, held_w}));
      if (out_valid && out_ready) begin
        check("exp_nonempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("word", 32'(cur_word()), 32'(e));
          if (e[EW-1]) fd_stage = 1;
        end
        acc_cnt++;
      end
      held_v = out_valid && !out_ready;
      held_w = cur_word();
    end
  end

  task automatic fill_exp();
    exp_q.delete();
    for (int id = 0; id < NS; id++)
      for (int a = 0; a < WPS; a++)
        exp_q.push_back({(id == NS - 1) && (a == WPS - 1), ID_W'(id), ADDR_W'(a), mem[id][a]});
  endtask

  task automatic do_frame(input bit wait_done, input bit stall, input bit xstarts, input bit chk_lat);
    int cyc;
    int fd0;
    int acc0;
    int stall_left;
    bit seen;
    logic [ADDR_W-1:0] a0;
    logic [ID_W-1:0] i0;
    fill_exp();
    fd0 = fd_count;
    acc0 = acc_cnt;
    stall_left = 5;
    out_ready = 1'b1;
    solvers_done = !wait_done;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    if (wait_done) begin
      a0 = rd_addr;
      i0 = rd_solver_id;
      repeat (10) begin
        @(negedge clock);
        check("wait_no_valid", 32'(out_valid), 0);
        check("wait_addr_hold", 32'({rd_solver_id, rd_addr}), 32'({i0, a0}));
        check("wait_busy", 32'(busy), 1);
      end
      @(posedge clock); #1 solvers_done = 1'b1;
    end
    if (chk_lat) begin
      @(negedge clock); check("busy_after_start", 32'(busy), 1);
      @(negedge clock); check("first_issue", 32'({rd_solver_id, rd_addr}), 0);
      @(negedge clock); check("valid_low_k2", 32'(out_valid), 0);
      @(negedge clock); check("valid_high_k3", 32'(out_valid), 1);
    end
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 400) begin
      @(posedge clock); #1;
      if (stall && (acc_cnt - acc0) >= 3) begin
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
      end
      if (xstarts) start = 1'($urandom_range(0, 1));
      @(negedge clock);
      if (frame_done) seen = 1'b1;
      cyc++;
    end
    check("frame_done_seen", 32'(seen), 1);
    if (chk_lat) check("fd_latency", 32'(cyc), 8);
    @(posedge clock); #1;
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    check("idle_busy", 32'(busy), 0);
    check("all_words", 32'(exp_q.size()), 0);
    check("word_count", 32'(acc_cnt - acc0), 32'(NS * WPS));
    check("fd_once", 32'(fd_count - fd0), 1);
  endtask

  task automatic reset_mid_stream();
    int cyc;
    int acc0;
    fill_exp();
    acc0 = acc_cnt;
    out_ready = 1'b1;
    solvers_done = 1'b1;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    cyc = 0;
    while ((acc_cnt - acc0) < 5 && cyc < 50) begin
      @(posedge clock);
      cyc++;
    end
    check("reached_word5", 32'(acc_cnt - acc0), 5);
    #2;
    check("pre_reset_valid", 32'(out_valid), 1);
    reset = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_fields", 32'(cur_word()), 0);
    check("rst_rd_port", 32'({rd_solver_id, rd_addr}), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    solvers_done = 1'b0;
    out_ready = 1'b1;
    for (int id = 0; id < NS; id++)
      for (int a = 0; a < WPS; a++)
        mem[id][a] = 8'(id * 16 + a);

    repeat (3) @(posedge clock);
    #1;
    check("reset_valid", 32'(out_valid), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_frame_done", 32'(frame_done), 0);
    check("reset_rd_port", 32'({rd_solver_id, rd_addr}), 0);
    check("reset_state", 32'(dbg_state), 0);
    reset = 1'b1;

    // basic readout with latency and throughput checks
    do_frame(1'b0, 1'b0, 1'b0, 1'b1);
    // start before the array is done
    do_frame(1'b1, 1'b0, 1'b0, 1'b0);
    // negative words through a stalled, then randomly throttled stream
    mem[0][1] = 8'h80;
    mem[1][2] = 8'hFF;
    do_frame(1'b0, 1'b1, 1'b0, 1'b0);
    // random contents, random backpressure, start pulses while busy
    for (int id = 0; id < NS; id++)
      for (int a = 0; a < WPS; a++)
        mem[id][a] = 8'($urandom_range(0, 255));
    do_frame(1'b0, 1'b1, 1'b1, 1'b0);
    // asynchronous reset mid-stream, then a fresh readout from (0,0)
    reset_mid_stream();
    for (int id = 0; id < NS; id++)
      for (int a = 0; a < WPS; a++)
        mem[id][a] = 8'(id * 16 + a);
    do_frame(1'b0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
